// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRIAL = 2'd1,
      DONE  = 2'd2
   } sar_state_e;

   localparam int SAR_WIDTH = 4;
   localparam logic [SAR_WIDTH-1:0] SAR_MSB = {1'b1, {(SAR_WIDTH-1){1'b0}}};

   // A comparator response is trustworthy only when exactly one flag is raised.
   function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
      return ({eq, gt, lt} == 3'b100) || ({eq, gt, lt} == 3'b010) ||
             ({eq, gt, lt} == 3'b001);
   endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-searches the comparator's A operand one bit per cycle, MSB first,
// by driving trial values on B and reading back eq/gt/lt.
module sar_search_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] guess,
   input  logic             eq_in,
   input  logic             gt_in,
   input  logic             lt_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             match,
   output logic             err
);

   localparam int                IW      = $clog2(WIDTH);
   localparam logic [WIDTH-1:0]  MSB     = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]  ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]     IDX_TOP = IW'(WIDTH-1);

   sar_state_e       state_q, state_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             match_q, match_d;
   logic             err_q, err_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] bit_cur, bit_nxt;

   assign bit_cur = ONE << idx_q;
   assign bit_nxt = bit_cur >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         guess_q  <= '0;
         result_q <= '0;
         match_q  <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= IDX_TOP;
      end else begin
         state_q  <= state_d;
         guess_q  <= guess_d;
         result_q <= result_d;
         match_q  <= match_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      guess_d  = guess_q;
      result_d = result_q;
      match_d  = match_q;
      err_d    = err_q;
      idx_d    = idx_q;
      case (state_q)
         IDLE: begin
            guess_d = '0;
            if (start) begin
               state_d = TRIAL;
               guess_d = MSB;
               idx_d   = IDX_TOP;
               match_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         TRIAL: begin
            if (!flags_onehot(eq_in, gt_in, lt_in)) begin
               state_d  = DONE;
               result_d = guess_q;
               match_d  = 1'b0;
               err_d    = 1'b1;
            end else if (eq_in) begin
               state_d  = DONE;
               result_d = guess_q;
               match_d  = 1'b1;
            end else if (idx_q != '0) begin
               guess_d = gt_in ? (guess_q | bit_nxt) : ((guess_q & ~bit_cur) | bit_nxt);
               idx_d   = idx_q - 1'b1;
            end else begin
               // Last bit: only "below 1" is consistent, and it means A == 0.
               state_d = DONE;
               if (lt_in && guess_q == ONE) begin
                  result_d = '0;
               end else begin
                  result_d = guess_q;
                  err_d    = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            guess_d = '0;
         end
         default: begin
            state_d = IDLE;
            guess_d = '0;
         end
      endcase
   end

   assign guess  = guess_q;
   assign result = result_q;
   assign match  = match_q;
   assign err    = err_q;
   assign busy   = (state_q == TRIAL);
   assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench: behavioural comparator between guess and the flag inputs,
// with per-trial flag overrides for fault responses.
module tb_sar_search_ctrl;

   typedef logic [3:0] v4_t [4];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] guess;
   logic       eq_in, gt_in, lt_in;
   logic       busy, done, match, err;
   logic [3:0] result;

   logic [3:0] a_op = 4'd0;
   logic [3:0] frc  = 4'd0;   // {enable, eq, gt, lt}

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   assign eq_in = frc[3] ? frc[2] : (a_op == guess);
   assign gt_in = frc[3] ? frc[1] : (a_op >  guess);
   assign lt_in = frc[3] ? frc[0] : (a_op <  guess);

   sar_search_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
      .eq_in(eq_in), .gt_in(gt_in), .lt_in(lt_in),
      .busy(busy), .done(done), .result(result), .match(match), .err(err)
   );

   task automatic run_search(input string nm, input logic [3:0] a, input v4_t f,
                             input v4_t eg, input int nt, input logic [3:0] er,
                             input logic em, input logic ee, input bit poke);
      int  cyc;
      bit  seen;
      int  extra;
      a_op = a;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc  = 1;
      seen = 1'b0;
      while (!seen && cyc <= 8) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (cyc <= nt) begin
               nvec++;
               if (busy !== 1'b1 || guess !== eg[cyc-1]) begin
                  nerr++;
                  $display("FAIL %s trial%0d: busy=%b guess=%0d, want busy=1 guess=%0d",
                           nm, cyc, busy, guess, eg[cyc-1]);
               end
            end
            frc = (cyc <= 4) ? f[cyc-1] : 4'd0;
            if (poke && cyc == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
         end
      end
      frc = 4'd0;
      nvec++;
      if (!seen || cyc != nt + 1) begin
         nerr++;
         $display("FAIL %s latency: done seen=%b at cycle %0d, want cycle %0d", nm, seen, cyc, nt + 1);
      end
      nvec++;
      if (result !== er || match !== em || err !== ee) begin
         nerr++;
         $display("FAIL %s outcome: result=%0d match=%b err=%b, want result=%0d match=%b err=%b",
                  nm, result, match, err, er, em, ee);
      end
      @(negedge clk);
      nvec++;
      if (done !== 1'b0 || busy !== 1'b0 || guess !== 4'd0 || result !== er) begin
         nerr++;
         $display("FAIL %s after_done: done=%b busy=%b guess=%0d result=%0d, want 0 0 0 %0d",
                  nm, done, busy, guess, result, er);
      end
      if (poke) begin
         extra = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         nvec++;
         if (extra != 0) begin
            nerr++;
            $display("FAIL %s ignored_start: %0d extra busy/done cycles, want 0", nm, extra);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      nvec++;
      if (guess !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || result !== 4'd0 ||
          match !== 1'b0 || err !== 1'b0) begin
         nerr++;
         $display("FAIL reset: guess=%0d busy=%b done=%b result=%0d match=%b err=%b, want all 0",
                  guess, busy, done, result, match, err);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_search();
      v4_t nf = '{4'd0, 4'd0, 4'd0, 4'd0};
      run_search("a5",  4'd5,  nf, '{4'd8, 4'd4, 4'd6, 4'd5},   4, 4'd5,  1'b1, 1'b0, 1'b0);
      run_search("a8",  4'd8,  nf, '{4'd8, 4'd0, 4'd0, 4'd0},   1, 4'd8,  1'b1, 1'b0, 1'b0);
      run_search("a0",  4'd0,  nf, '{4'd8, 4'd4, 4'd2, 4'd1},   4, 4'd0,  1'b0, 1'b0, 1'b0);
      run_search("a15", 4'd15, nf, '{4'd8, 4'd12, 4'd14, 4'd15}, 4, 4'd15, 1'b1, 1'b0, 1'b0);
      run_search("a10", 4'd10, nf, '{4'd8, 4'd12, 4'd10, 4'd0}, 3, 4'd10, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_bad_flags();
      run_search("eqgt_t2", 4'd5, '{4'd0, 4'b1110, 4'd0, 4'd0},
                 '{4'd8, 4'd4, 4'd0, 4'd0}, 2, 4'd4, 1'b0, 1'b1, 1'b0);
      run_search("none_t1", 4'd5, '{4'b1000, 4'd0, 4'd0, 4'd0},
                 '{4'd8, 4'd0, 4'd0, 4'd0}, 1, 4'd8, 1'b0, 1'b1, 1'b0);
      run_search("gt_all", 4'd3, '{4'b1010, 4'b1010, 4'b1010, 4'b1010},
                 '{4'd8, 4'd12, 4'd14, 4'd15}, 4, 4'd15, 1'b0, 1'b1, 1'b0);
      run_search("gt_gt_gt_lt", 4'd3, '{4'b1010, 4'b1010, 4'b1010, 4'b1001},
                 '{4'd8, 4'd12, 4'd14, 4'd15}, 4, 4'd15, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_search("busy_start", 4'd5, '{4'd0, 4'd0, 4'd0, 4'd0},
                 '{4'd8, 4'd4, 4'd6, 4'd5}, 4, 4'd5, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_mid_reset();
      int tmo;
      int dones;
      a_op = 4'd5;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      tmo = 0;
      while (guess !== 4'd6 && tmo < 8) begin
         @(negedge clk);
         tmo++;
      end
      nvec++;
      if (guess !== 4'd6 || busy !== 1'b1) begin
         nerr++;
         $display("FAIL mid_reset_reach: guess=%0d busy=%b, want 6 1", guess, busy);
      end
      rst_n = 1'b0;
      #1;
      nvec++;
      if (guess !== 4'd0 || busy !== 1'b0 || result !== 4'd0 || match !== 1'b0 || done !== 1'b0) begin
         nerr++;
         $display("FAIL mid_reset: guess=%0d busy=%b result=%0d match=%b done=%b, want all 0",
                  guess, busy, result, match, done);
      end
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      if (done) dones++;
      nvec++;
      if (dones != 0) begin
         nerr++;
         $display("FAIL mid_reset_nodone: %0d done cycles, want 0", dones);
      end
      run_search("after_rst", 4'd5, '{4'd0, 4'd0, 4'd0, 4'd0},
                 '{4'd8, 4'd4, 4'd6, 4'd5}, 4, 4'd5, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_search();
      test_bad_flags();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
